dcache_perf_monitor: RTL and testbench
======================================

DCACHE_PERF_MONITOR -- requirements
Module: dcache_perf_monitor

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning width of the monitored CPU address.
REQ-002 SHALL have parameter CNT_W, default 32, meaning width of every event counter (range 8..64).
REQ-003 SHALL have parameter DEPTH, default 8, meaning trace FIFO entries (power of 2, range 2..64).
REQ-004 SHALL have port clk_i, input, 1, the single clock; all logic samples on posedge.
REQ-005 SHALL have port rst_i, input, 1, reset: asynchronous, active-low.
REQ-006 SHALL have port enable_i, input, 1: 1 = count and trace; 0 = freeze all counters and FIFO pushes.
REQ-007 SHALL have port clr_i, input, 1: synchronous clear of counters, drop counter and FIFO.
REQ-008 SHALL have port stall_i, input, 1: cache stall to CPU.
REQ-009 SHALL have port fsm_idle_i, input, 1: cache controller FSM is in its idle state.
REQ-010 SHALL have port dirty_i, input, 1: selected victim line is dirty.
REQ-011 SHALL have port mem_read_i, input, 1, and port mem_write_i, input, 1: CPU request type.
REQ-012 SHALL have port addr_i, input, ADDR_W: CPU request address.
REQ-013 SHALL have ports rd_hit_o, rd_miss_o, wr_hit_o, wr_miss_o, wb_o, output, CNT_W each: event counts.
REQ-014 SHALL have port trc_valid_o, output, 1, and port trc_ready_i, input, 1: trace pop handshake.
REQ-015 SHALL have port trc_data_o, output, ADDR_W+3: {is_write, writeback, reserved 0, addr}.
REQ-016 SHALL have port trc_drop_o, output, CNT_W: count of misses lost to a full FIFO.

Function
REQ-017 SHALL classify once per posedge: miss = stall_i & fsm_idle_i; hit candidate = ~stall_i; stall_i & ~fsm_idle_i = no event.
REQ-018 SHALL treat a miss as a write miss if mem_write_i=1, else a read miss if mem_read_i=1, else no event; mem_write_i has priority.
REQ-019 SHALL also increment wb_o on a miss event with dirty_i=1.
REQ-020 SHALL hold an internal pending flag: set on every miss cycle, cleared on every ~stall_i cycle.
REQ-021 SHALL count a hit (write priority, as REQ-018) only when ~stall_i and pending flag was 0 in that cycle; the first unstalled cycle after a miss is not a hit.
REQ-022 SHALL update counters one cycle after the qualifying edge (registered outputs), latency 1.
REQ-023 SHALL saturate every counter at 2^CNT_W-1; no wrap.
REQ-024 SHALL, when enable_i=0, leave counters, drop counter and FIFO contents unchanged, but still update the pending flag and allow pops.
REQ-025 SHALL give clr_i priority over a simultaneous event: all counters 0, FIFO empty, pending flag 0.
REQ-026 SHALL present trc_valid_o=1 whenever the FIFO is non-empty; an entry pops on trc_valid_o & trc_ready_i.
REQ-027 SHALL push one entry per miss event; when full with no pop in the same cycle, drop it and increment trc_drop_o.
REQ-028 SHALL accept a push when full if a pop occurs in the same cycle; occupancy stays DEPTH.
REQ-029 SHALL wrap read/write pointers modulo DEPTH and deliver entries in FIFO order.

Reset
REQ-030 SHALL, while rst_i=0, force all counters 0, trc_drop_o 0, FIFO empty, trc_valid_o 0, trc_data_o 0, pending flag 0.
REQ-031 SHALL abandon any in-progress miss sequence on reset; the first unstalled cycle after reset release counts as a hit if a request is present.

Configuration
REQ-032 SHALL compile the trace FIFO only when macro DCACHE_PERF_MONITOR_TRACE_EN is defined.
REQ-033 SHALL, with the macro undefined, tie trc_valid_o 0, trc_data_o 0, trc_drop_o 0, ignore trc_ready_i, and keep counters identical.

Verification
REQ-034 SHALL cover: read with stall_i=0 and no prior miss -> rd_hit_o=1 next cycle, others 0.
REQ-035 SHALL cover: write miss with dirty_i=1, stall 10 cycles (idle only in first), then release -> wr_miss_o=1, wb_o=1, wr_hit_o=0, one trace entry {1,1,0,addr}.
REQ-036 SHALL cover: DEPTH=8, 10 read misses with trc_ready_i=0 -> 8 entries held, trc_drop_o=2; then drain -> addresses in push order.
REQ-037 SHALL cover: CNT_W=8, 300 read hits -> rd_hit_o=255.
REQ-038 SHALL cover: clr_i asserted in a miss cycle -> all counters 0, trc_valid_o 0 next cycle.
REQ-039 SHALL cover: rst_i pulsed low mid-stall -> all outputs 0 immediately (asynchronous), no hit suppression afterwards.

Source files
------------

// File: rtl/dcache_perf_monitor.sv
// Data-cache performance monitor: read/write hit/miss and writeback event counters.
// Optional miss-trace FIFO built only when DCACHE_PERF_MONITOR_TRACE_EN is defined.
module dcache_perf_monitor #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              clr_i,
  input  logic              stall_i,
  input  logic              fsm_idle_i,
  input  logic              dirty_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [CNT_W-1:0]  rd_hit_o,
  output logic [CNT_W-1:0]  rd_miss_o,
  output logic [CNT_W-1:0]  wr_hit_o,
  output logic [CNT_W-1:0]  wr_miss_o,
  output logic [CNT_W-1:0]  wb_o,
  output logic              trc_valid_o,
  input  logic              trc_ready_i,
  output logic [ADDR_W+2:0] trc_data_o,
  output logic [CNT_W-1:0]  trc_drop_o
);
  localparam int NEV = 5;
  localparam int E_RH = 0, E_RM = 1, E_WH = 2, E_WM = 3, E_WB = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic pending_q, pending_d;
  logic miss, hit_ok, miss_ev;
  logic [NEV-1:0] ev;
  logic [NEV-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // The first unstalled cycle after a miss is the refill handoff, not a hit.
  assign miss   = stall_i & fsm_idle_i;
  assign hit_ok = ~stall_i & ~pending_q;

  always_comb begin
    ev        = '0;
    ev[E_WM]  = miss & mem_write_i;
    ev[E_RM]  = miss & ~mem_write_i & mem_read_i;
    ev[E_WH]  = hit_ok & mem_write_i;
    ev[E_RH]  = hit_ok & ~mem_write_i & mem_read_i;
    miss_ev   = ev[E_WM] | ev[E_RM];
    ev[E_WB]  = miss_ev & dirty_i;
  end

  always_comb begin
    pending_d = pending_q;
    if (clr_i)        pending_d = 1'b0;
    else if (miss)    pending_d = 1'b1;
    else if (!stall_i) pending_d = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NEV; i++) begin
      if (clr_i) cnt_d[i] = '0;
      else if (enable_i && ev[i] && cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pending_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign rd_hit_o  = cnt_q[E_RH];
  assign rd_miss_o = cnt_q[E_RM];
  assign wr_hit_o  = cnt_q[E_WH];
  assign wr_miss_o = cnt_q[E_WM];
  assign wb_o      = cnt_q[E_WB];

`ifdef DCACHE_PERF_MONITOR_TRACE_EN
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] OCC_FULL = (PW+1)'(DEPTH);

  logic [ADDR_W+2:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_q, rd_q;
  logic [PW:0]       occ_q;
  logic [CNT_W-1:0]  drop_q;
  logic              full, pop, push_req, push, drop_ev;

  assign full     = (occ_q == OCC_FULL);
  assign pop      = trc_valid_o & trc_ready_i;
  assign push_req = enable_i & miss_ev & ~clr_i;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push     = push_req & (~full | pop);
  assign drop_ev  = push_req & full & ~pop;

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= {mem_write_i, dirty_i, 1'b0, addr_i};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_q <= '0; rd_q <= '0; occ_q <= '0; drop_q <= '0;
    end else if (clr_i) begin
      wr_q <= '0; rd_q <= '0; occ_q <= '0; drop_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
      if (drop_ev && drop_q != CNT_MAX) drop_q <= drop_q + CNT_ONE;
    end
  end

  assign trc_valid_o = (occ_q != '0);
  assign trc_data_o  = trc_valid_o ? mem_q[rd_q] : '0;
  assign trc_drop_o  = drop_q;
`else
  logic unused_trc;
  assign unused_trc  = ^{trc_ready_i, addr_i};
  assign trc_valid_o = 1'b0;
  assign trc_data_o  = '0;
  assign trc_drop_o  = '0;
`endif
endmodule

// File: tb/tb_dcache_perf_monitor.sv
// Directed bench for dcache_perf_monitor (CNT_W=8, DEPTH=8); trace checks follow the build macro.
module tb_dcache_perf_monitor;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 8;
  localparam int DEPTH  = 8;

  logic clk = 1'b0;
  logic rst_n, enable, clr, stall, fsm_idle, dirty, mem_rd, mem_wr, trc_ready;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  rd_hit, rd_miss, wr_hit, wr_miss, wb, trc_drop;
  logic              trc_valid;
  logic [ADDR_W+2:0] trc_data;

  int n_cmp = 0;
  int n_err = 0;

  dcache_perf_monitor #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .enable_i(enable), .clr_i(clr), .stall_i(stall),
    .fsm_idle_i(fsm_idle), .dirty_i(dirty), .mem_read_i(mem_rd), .mem_write_i(mem_wr),
    .addr_i(addr), .rd_hit_o(rd_hit), .rd_miss_o(rd_miss), .wr_hit_o(wr_hit),
    .wr_miss_o(wr_miss), .wb_o(wb), .trc_valid_o(trc_valid), .trc_ready_i(trc_ready),
    .trc_data_o(trc_data), .trc_drop_o(trc_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int rh, input int rm, input int wh,
                         input int wm, input int w);
    chk({tag, ".rd_hit"},  64'(rd_hit),  64'(rh));
    chk({tag, ".rd_miss"}, 64'(rd_miss), 64'(rm));
    chk({tag, ".wr_hit"},  64'(wr_hit),  64'(wh));
    chk({tag, ".wr_miss"}, 64'(wr_miss), 64'(wm));
    chk({tag, ".wb"},      64'(wb),      64'(w));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr;
    clr = 1'b1; tick; clr = 1'b0;
  endtask

  logic [ADDR_W-1:0] exp_q [$];

  initial begin
    rst_n = 1'b0; enable = 1'b1; clr = 1'b0; stall = 1'b0; fsm_idle = 1'b1;
    dirty = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; trc_ready = 1'b0; addr = '0;
    tick; tick;
    chk_cnt("reset", 0, 0, 0, 0, 0);
    chk("reset.valid", 64'(trc_valid), 64'd0);
    chk("reset.data",  64'(trc_data),  64'd0);
    chk("reset.drop",  64'(trc_drop),  64'd0);
    rst_n = 1'b1;

    // plain read hit, then write hit
    mem_rd = 1'b1; tick; mem_rd = 1'b0;
    chk_cnt("rdhit", 1, 0, 0, 0, 0);
    mem_wr = 1'b1; tick; mem_wr = 1'b0;
    chk_cnt("wrhit", 1, 0, 1, 0, 0);
    do_clr;
    chk_cnt("clr", 0, 0, 0, 0, 0);

    // dirty write miss: idle only in first stall cycle, 10 stall cycles, release
    stall = 1'b1; fsm_idle = 1'b1; mem_wr = 1'b1; dirty = 1'b1; addr = 32'hDEAD_BEE0;
    tick;
    fsm_idle = 1'b0;
    repeat (9) tick;
    stall = 1'b0; fsm_idle = 1'b1;
    tick;
    mem_wr = 1'b0; dirty = 1'b0;
    chk_cnt("wrmiss", 0, 0, 0, 1, 1);
`ifdef DCACHE_PERF_MONITOR_TRACE_EN
    chk("wrmiss.valid", 64'(trc_valid), 64'd1);
    chk("wrmiss.data",  64'(trc_data),  64'({3'b110, 32'hDEAD_BEE0}));
    trc_ready = 1'b1; tick; trc_ready = 1'b0;
    chk("wrmiss.popped", 64'(trc_valid), 64'd0);
`else
    chk("wrmiss.valid", 64'(trc_valid), 64'd0);
    chk("wrmiss.data",  64'(trc_data),  64'd0);
`endif
    mem_wr = 1'b1; tick; mem_wr = 1'b0;
    chk_cnt("wrhit2", 0, 0, 1, 1, 1);

    // clean read miss with immediate release
    stall = 1'b1; mem_rd = 1'b1; addr = 32'h40;
    tick;
    stall = 1'b0;
    tick;
    mem_rd = 1'b0;
    chk_cnt("rdmiss", 0, 1, 1, 1, 1);
`ifdef DCACHE_PERF_MONITOR_TRACE_EN
    chk("rdmiss.data", 64'(trc_data), 64'h40);
`endif
    trc_ready = 1'b1; tick; trc_ready = 1'b0;

    // disabled: nothing counts, but the pending flag still tracks the miss
    enable = 1'b0; mem_rd = 1'b1;
    tick;
    stall = 1'b1; tick;
    enable = 1'b1; stall = 1'b0;
    tick;
    chk_cnt("dis", 0, 1, 1, 1, 1);
    chk("dis.valid", 64'(trc_valid), 64'd0);
    tick;
    mem_rd = 1'b0;
    chk_cnt("dis.after", 1, 1, 1, 1, 1);

    // clear wins over a simultaneous miss and drops the pending flag
    stall = 1'b1; mem_rd = 1'b1; clr = 1'b1;
    tick;
    clr = 1'b0;
    chk_cnt("clrmiss", 0, 0, 0, 0, 0);
    chk("clrmiss.valid", 64'(trc_valid), 64'd0);
    stall = 1'b0;
    tick;
    mem_rd = 1'b0;
    chk_cnt("clrmiss.hit", 1, 0, 0, 0, 0);

    // overfill the trace FIFO, then push-with-pop while full, then drain
    do_clr;
    stall = 1'b1; mem_rd = 1'b1;
    for (int i = 0; i < 10; i++) begin
      addr = 32'h100 + i;
      tick;
    end
    addr = 32'h10A; trc_ready = 1'b1;
    tick;
    trc_ready = 1'b0; stall = 1'b0; mem_rd = 1'b0;
    tick;
    chk_cnt("fill", 0, 11, 0, 0, 0);
`ifdef DCACHE_PERF_MONITOR_TRACE_EN
    chk("fill.drop",  64'(trc_drop),  64'd2);
    chk("fill.valid", 64'(trc_valid), 64'd1);
    for (int i = 1; i < 8; i++) exp_q.push_back(32'h100 + i);
    exp_q.push_back(32'h10A);
    trc_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain%0d.valid", k), 64'(trc_valid), 64'd1);
      chk($sformatf("drain%0d.data", k),  64'(trc_data),  64'(exp_q[k]));
      tick;
    end
    trc_ready = 1'b0;
    chk("drain.empty", 64'(trc_valid), 64'd0);
`else
    chk("fill.drop",  64'(trc_drop),  64'd0);
    chk("fill.valid", 64'(trc_valid), 64'd0);
`endif

    // saturation at 255 for 8-bit counters
    do_clr;
    mem_rd = 1'b1;
    repeat (300) tick;
    mem_rd = 1'b0;
    chk_cnt("sat", 255, 0, 0, 0, 0);

    // asynchronous reset in the middle of a miss stall
    do_clr;
    stall = 1'b1; fsm_idle = 1'b1; mem_rd = 1'b1; addr = 32'h200;
    tick;
    fsm_idle = 1'b0;
    tick;
    chk_cnt("prerst", 0, 1, 0, 0, 0);
`ifdef DCACHE_PERF_MONITOR_TRACE_EN
    chk("prerst.valid", 64'(trc_valid), 64'd1);
`endif
    #2 rst_n = 1'b0;
    #1;
    chk_cnt("arst", 0, 0, 0, 0, 0);
    chk("arst.valid", 64'(trc_valid), 64'd0);
    chk("arst.data",  64'(trc_data),  64'd0);
    chk("arst.drop",  64'(trc_drop),  64'd0);
    #2 rst_n = 1'b1;
    stall = 1'b0; fsm_idle = 1'b1;
    tick;
    mem_rd = 1'b0;
    chk_cnt("postrst", 1, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
